// File: rtl/eth_pkg.sv
// Shared types and defaults for the ethernet RX fetch path.
//  - fetch_state_t : fetch FSM state encoding
//  - MAX_COUNT_DEF : data count value meaning "invalid frame"
//  - TIMEOUT_DEF   : cycles allowed between a request and its response
//  - rlast_mismatch: true when rlast disagrees with the expected last beat
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_AR = 3'd1,
    ST_CNT_R  = 3'd2,
    ST_DAT_AR = 3'd3,
    ST_DAT_R  = 3'd4
  } fetch_state_t;

  localparam logic [15:0] MAX_COUNT_DEF = 16'h1FFF;
  localparam int          TIMEOUT_DEF   = 1024;

  // rlast must be high exactly on the final beat of the burst.
  function automatic logic rlast_mismatch(input logic rlast, input logic at_end);
    return rlast ^ at_end;
  endfunction

endpackage

// File: rtl/addr_defines.sv
// Ethernet peripheral slave register map addresses.
// Shared by every block that talks to the peripheral over AXI.
`ifndef ADDR_DEFINES_SV
`define ADDR_DEFINES_SV

`define ETHERNET_RX_DATA        32'h4000_0100
`define ETHERNET_RX_DATA_COUNT  32'h4000_0104

`endif

// File: rtl/eth_skid_buf.sv
// Two-entry skid buffer with valid/ready on both sides.
// Ports:
//  clk, rst              clock, asynchronous active-high reset (flushes)
//  in_valid/in_ready     upstream handshake; in_ready = not full
//  in_data [W]           upstream word
//  out_valid/out_ready   downstream handshake; out_valid = not empty
//  out_data [W]          downstream word, held stable while stalled
// Output is taken straight from storage registers, so a word pushed on
// one edge is visible the following cycle and a full-rate stream has no
// bubbles (occupancy never exceeds one while out_ready stays high).
module eth_skid_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem_r [2];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   count_r;
  logic         push_s;
  logic         pop_s;

  assign in_ready  = (count_r != 2'd2);
  assign out_valid = (count_r != 2'd0);
  assign out_data  = mem_r[rd_ptr_r];
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= in_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/eth_rx_fetch_master.sv
// AXI read initiator draining received frames from the ethernet peripheral.
// On rx_ready_int it reads the RX data count register, then bursts the
// frame out of the RX data register and streams it through a skid buffer.
// Ports:
//  clk_100_mhz, rst          clock, asynchronous active-high reset
//  rx_ready_int              frame-ready level, sampled only in IDLE
//  axi_ar* / axi_r*          AXI read address / read data channels
//  out_data/valid/last/ready frame word stream (last = final word)
//  frame_len                 word count of current/last frame (count+1)
//  frame_done                pulse: last word of frame entered the buffer
//  fetch_err                 pulse: timeout or misplaced rlast
`ifndef ETHERNET_RX_DATA
`include "addr_defines.sv"
`endif

module eth_rx_fetch_master
  import eth_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter logic [15:0] MAX_COUNT = MAX_COUNT_DEF,
  parameter int          TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clk_100_mhz,
  input  logic              rst,
  input  logic              rx_ready_int,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  input  logic [DATA_W-1:0] axi_rdata,
  input  logic              axi_rvalid,
  input  logic              axi_rlast,
  output logic              axi_rready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic [15:0]       frame_len,
  output logic              frame_done,
  output logic              fetch_err
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  fetch_state_t      state_r;
  fetch_state_t      state_s;
  logic [TW-1:0]     timer_r;
  logic [15:0]       cnt_r;
  logic [15:0]       beat_r;
  logic [15:0]       frame_len_r;
  logic              frame_done_r;
  logic              fetch_err_r;
  logic              frame_err_r;

  logic              arvalid_s;
  logic [ADDR_W-1:0] araddr_s;
  logic              rready_s;
  logic              push_s;
  logic              hs_s;
  logic              abort_s;
  logic              cnt_load_s;
  logic              len_load_s;
  logic              beat_clr_s;
  logic              done_s;
  logic              rlast_err_s;
  logic              timer_limit_s;
  logic              at_end_s;
  logic              skid_in_ready_s;
  logic [DATA_W:0]   skid_out_s;

  assign timer_limit_s = (timer_r == TW'(TIMEOUT - 1));
  assign at_end_s      = (beat_r == cnt_r);

  // Next state and AXI request signals; a handshake always wins over a timeout.
  always_comb begin
    state_s     = state_r;
    arvalid_s   = 1'b0;
    araddr_s    = '0;
    rready_s    = 1'b0;
    push_s      = 1'b0;
    hs_s        = 1'b0;
    abort_s     = 1'b0;
    cnt_load_s  = 1'b0;
    len_load_s  = 1'b0;
    beat_clr_s  = 1'b0;
    done_s      = 1'b0;
    rlast_err_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rx_ready_int) begin
          state_s = ST_CNT_AR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CNT_AR: begin
        arvalid_s = 1'b1;
        araddr_s  = ADDR_W'(`ETHERNET_RX_DATA_COUNT);
        if (axi_arready) begin
          hs_s    = 1'b1;
          state_s = ST_CNT_R;
        end else if (timer_limit_s) begin
          abort_s = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_CNT_AR;
        end
      end
      ST_CNT_R: begin
        rready_s = 1'b1;
        if (axi_rvalid) begin
          hs_s       = 1'b1;
          cnt_load_s = 1'b1;
          // Invalid frame: the peripheral discards it on its own.
          if (axi_rdata[15:0] == MAX_COUNT) begin
            state_s = ST_IDLE;
          end else begin
            len_load_s = 1'b1;
            state_s    = ST_DAT_AR;
          end
        end else if (timer_limit_s) begin
          abort_s = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_CNT_R;
        end
      end
      ST_DAT_AR: begin
        arvalid_s = 1'b1;
        araddr_s  = ADDR_W'(`ETHERNET_RX_DATA);
        if (axi_arready) begin
          hs_s       = 1'b1;
          beat_clr_s = 1'b1;
          state_s    = ST_DAT_R;
        end else if (timer_limit_s) begin
          abort_s = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DAT_AR;
        end
      end
      ST_DAT_R: begin
        rready_s = skid_in_ready_s;
        if (axi_rvalid && skid_in_ready_s) begin
          hs_s   = 1'b1;
          push_s = 1'b1;
          // One error pulse per frame, however many beats disagree with rlast.
          if (rlast_mismatch(axi_rlast, at_end_s) && !frame_err_r) begin
            rlast_err_s = 1'b1;
          end else begin
            rlast_err_s = 1'b0;
          end
          // Frame length comes from the count, not from rlast.
          if (at_end_s) begin
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DAT_R;
          end
        end else if (timer_limit_s) begin
          abort_s = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DAT_R;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, timeout counter, count/beat bookkeeping and status pulses.
  always_ff @(posedge clk_100_mhz or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      timer_r      <= '0;
      cnt_r        <= 16'd0;
      beat_r       <= 16'd0;
      frame_len_r  <= 16'd0;
      frame_done_r <= 1'b0;
      fetch_err_r  <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      if ((state_r == ST_IDLE) || hs_s || abort_s) begin
        timer_r <= '0;
      end else begin
        timer_r <= timer_r + TW'(1);
      end
      if (cnt_load_s) begin
        cnt_r <= axi_rdata[15:0];
      end
      if (len_load_s) begin
        frame_len_r <= axi_rdata[15:0] + 16'd1;
      end
      if (beat_clr_s) begin
        beat_r      <= 16'd0;
        frame_err_r <= 1'b0;
      end else if (push_s) begin
        beat_r <= beat_r + 16'd1;
        if (rlast_err_s) begin
          frame_err_r <= 1'b1;
        end
      end
      frame_done_r <= done_s;
      fetch_err_r  <= abort_s | rlast_err_s;
    end
  end

  eth_skid_buf #(
    .W (DATA_W + 1)
  ) u_skid (
    .clk       (clk_100_mhz),
    .rst       (rst),
    .in_valid  (push_s),
    .in_ready  (skid_in_ready_s),
    .in_data   ({axi_rdata, at_end_s}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (skid_out_s)
  );

  assign axi_arvalid = arvalid_s;
  assign axi_araddr  = araddr_s;
  assign axi_rready  = rready_s;
  assign out_data    = skid_out_s[DATA_W:1];
  assign out_last    = skid_out_s[0];
  assign frame_len   = frame_len_r;
  assign frame_done  = frame_done_r;
  assign fetch_err   = fetch_err_r;

endmodule

// File: tb/tb_eth_rx_fetch_master.sv
// Directed bench for eth_rx_fetch_master with a small AXI slave and stream sink.
`ifndef ETHERNET_RX_DATA
`include "addr_defines.sv"
`endif

module tb_eth_rx_fetch_master;

  logic        clk_100_mhz = 1'b0;
  logic        rst;
  logic        rx_ready_int;
  logic [31:0] axi_araddr;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic        axi_rvalid;
  logic        axi_rlast;
  logic        axi_rready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic [15:0] frame_len;
  logic        frame_done;
  logic        fetch_err;

  localparam logic [31:0] A_CNT = `ETHERNET_RX_DATA_COUNT;
  localparam logic [31:0] A_DAT = `ETHERNET_RX_DATA;

  always #5 clk_100_mhz = ~clk_100_mhz;

  eth_rx_fetch_master dut (
    .clk_100_mhz  (clk_100_mhz),
    .rst          (rst),
    .rx_ready_int (rx_ready_int),
    .axi_araddr   (axi_araddr),
    .axi_arvalid  (axi_arvalid),
    .axi_arready  (axi_arready),
    .axi_rdata    (axi_rdata),
    .axi_rvalid   (axi_rvalid),
    .axi_rlast    (axi_rlast),
    .axi_rready   (axi_rready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .frame_len    (frame_len),
    .frame_done   (frame_done),
    .fetch_err    (fetch_err)
  );

  int n_vec = 0;
  int n_err = 0;

  // Slave configuration, written by the test sequence only.
  logic [15:0] cfg_count;
  logic [31:0] cfg_base;
  int          cfg_rlast_beat;
  logic        cfg_arready_en;
  int          cfg_mode;   // 0: out_ready=1, 1: toggle every 3 cycles, 2: out_ready=0

  // Observations, written by the slave/monitor process only.
  logic [31:0] ar_log[$];
  logic [32:0] out_log[$];
  int          out_cyc[$];
  int          cyc = 0;
  int          n_done = 0;
  int          n_err_pulse = 0;
  int          n_arvalid_cyc = 0;
  int          data_hs = 0;
  int          stall_hs = 0;
  int          max_stall_hs = 0;
  int          unstable = 0;

  // AXI slave and stream sink: drive at negedge, observe at negedge+1.
  initial begin : slave
    bit          r_active;
    bit          r_is_cnt;
    int          r_beat;
    int          r_total;
    bit          prev_hold;
    logic [32:0] prev_word;
    bit          r_hs;
    r_active    = 1'b0;
    r_is_cnt    = 1'b0;
    r_beat      = 0;
    r_total     = 0;
    prev_hold   = 1'b0;
    prev_word   = '0;
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    axi_rdata   = 32'd0;
    axi_rlast   = 1'b0;
    out_ready   = 1'b1;
    forever begin
      @(negedge clk_100_mhz);
      cyc++;
      if (rst) begin
        r_active  = 1'b0;
        prev_hold = 1'b0;
      end
      out_ready   = (cfg_mode == 0) ? 1'b1 : (cfg_mode == 2) ? 1'b0 : (((cyc / 3) % 2) == 0);
      axi_arready = cfg_arready_en;
      axi_rvalid  = r_active;
      if (r_is_cnt) begin
        axi_rdata = {16'h0000, cfg_count};
        axi_rlast = 1'b1;
      end else begin
        axi_rdata = cfg_base + 32'(r_beat);
        axi_rlast = (r_beat == cfg_rlast_beat);
      end
      #1;
      if (!rst) begin
        if (prev_hold && out_valid && ({out_last, out_data} !== prev_word)) unstable++;
        prev_hold = out_valid && !out_ready;
        prev_word = {out_last, out_data};
        if (axi_arvalid) n_arvalid_cyc++;
        if (frame_done) n_done++;
        if (fetch_err) n_err_pulse++;
        r_hs = axi_rvalid && axi_rready;
        if (!out_ready) begin
          if (r_hs && !r_is_cnt) stall_hs++;
          if (stall_hs > max_stall_hs) max_stall_hs = stall_hs;
        end else begin
          stall_hs = 0;
        end
        if (r_hs) begin
          r_beat++;
          if (!r_is_cnt) data_hs++;
          if (r_beat == r_total) r_active = 1'b0;
        end
        if (axi_arvalid && axi_arready) begin
          ar_log.push_back(axi_araddr);
          r_active = 1'b1;
          r_beat   = 0;
          r_is_cnt = (axi_araddr == A_CNT);
          r_total  = r_is_cnt ? 1 : int'(cfg_count) + 1;
        end
        if (out_valid && out_ready) begin
          out_log.push_back({out_last, out_data});
          out_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk_100_mhz);
    #2;
  endtask

  task automatic start_frame();
    rx_ready_int = 1'b1;
    step();
    rx_ready_int = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget);
    int k;
    k = 0;
    while (out_log.size() < n && k < budget) begin
      step();
      k++;
    end
    for (int j = 0; j < 6; j++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int j = 0; j < 3; j++) step();
    n_vec++;
    if ({axi_arvalid, axi_rready, out_valid, out_last, frame_done, fetch_err} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctl: got %b expected 000000",
               {axi_arvalid, axi_rready, out_valid, out_last, frame_done, fetch_err});
    end
    n_vec++;
    if (axi_araddr !== 32'd0) begin
      n_err++;
      $display("FAIL reset_araddr: got %h expected 00000000", axi_araddr);
    end
    n_vec++;
    if (out_data !== 32'd0) begin
      n_err++;
      $display("FAIL reset_out_data: got %h expected 00000000", out_data);
    end
    rst = 1'b0;
    for (int j = 0; j < 3; j++) step();
    n_vec++;
    if (frame_len !== 16'd0 || axi_arvalid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got len=%h arvalid=%b expected len=0000 arvalid=0", frame_len, axi_arvalid);
    end
  endtask

  task automatic test_basic();
    int a0, o0, d0, e0;
    logic [32:0] exp_w;
    cfg_count = 16'd3; cfg_base = 32'hA000_0000; cfg_rlast_beat = 3; cfg_mode = 0;
    a0 = ar_log.size(); o0 = out_log.size(); d0 = n_done; e0 = n_err_pulse;
    start_frame();
    wait_words(o0 + 4, 100);
    n_vec++;
    if (ar_log.size() - a0 !== 2 || ar_log[a0] !== A_CNT || ar_log[a0+1] !== A_DAT) begin
      n_err++;
      $display("FAIL basic_ar: got %0d requests expected 2 (count then data)", ar_log.size() - a0);
    end
    n_vec++;
    if (out_log.size() - o0 !== 4) begin
      n_err++;
      $display("FAIL basic_nwords: got %0d expected 4", out_log.size() - o0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp_w = {(i == 3), 32'hA000_0000 + 32'(i)};
        n_vec++;
        if (out_log[o0+i] !== exp_w) begin
          n_err++;
          $display("FAIL basic_word%0d: got %h expected %h", i, out_log[o0+i], exp_w);
        end
      end
      n_vec++;
      if (out_cyc[o0+3] - out_cyc[o0] !== 3) begin
        n_err++;
        $display("FAIL basic_bubbles: got span %0d expected 3", out_cyc[o0+3] - out_cyc[o0]);
      end
    end
    n_vec++;
    if (frame_len !== 16'd4) begin
      n_err++;
      $display("FAIL basic_len: got %h expected 0004", frame_len);
    end
    n_vec++;
    if (n_done - d0 !== 1 || n_err_pulse - e0 !== 0) begin
      n_err++;
      $display("FAIL basic_pulses: got done=%0d err=%0d expected done=1 err=0", n_done - d0, n_err_pulse - e0);
    end
  endtask

  task automatic test_invalid_count();
    int a0, o0, d0, e0;
    cfg_count = 16'h1FFF; cfg_base = 32'hF000_0000; cfg_rlast_beat = 0; cfg_mode = 0;
    a0 = ar_log.size(); o0 = out_log.size(); d0 = n_done; e0 = n_err_pulse;
    start_frame();
    for (int j = 0; j < 30; j++) step();
    n_vec++;
    if (ar_log.size() - a0 !== 1 || ar_log[a0] !== A_CNT) begin
      n_err++;
      $display("FAIL invalid_ar: got %0d requests expected 1 to count register", ar_log.size() - a0);
    end
    n_vec++;
    if (out_log.size() - o0 !== 0 || n_done - d0 !== 0 || n_err_pulse - e0 !== 0) begin
      n_err++;
      $display("FAIL invalid_quiet: got words=%0d done=%0d err=%0d expected 0 0 0",
               out_log.size() - o0, n_done - d0, n_err_pulse - e0);
    end
    n_vec++;
    if ({axi_arvalid, axi_rready, out_valid} !== 3'b000 || frame_len !== 16'd4) begin
      n_err++;
      $display("FAIL invalid_idle: got ctl=%b len=%h expected ctl=000 len=0004",
               {axi_arvalid, axi_rready, out_valid}, frame_len);
    end
  endtask

  task automatic test_backpressure();
    int o0, d0, u0;
    logic [32:0] exp_w;
    cfg_count = 16'd7; cfg_base = 32'hB000_0000; cfg_rlast_beat = 7; cfg_mode = 1;
    o0 = out_log.size(); d0 = n_done; u0 = unstable;
    start_frame();
    wait_words(o0 + 8, 400);
    cfg_mode = 0;
    n_vec++;
    if (out_log.size() - o0 !== 8) begin
      n_err++;
      $display("FAIL bp_nwords: got %0d expected 8", out_log.size() - o0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        exp_w = {(i == 7), 32'hB000_0000 + 32'(i)};
        n_vec++;
        if (out_log[o0+i] !== exp_w) begin
          n_err++;
          $display("FAIL bp_word%0d: got %h expected %h", i, out_log[o0+i], exp_w);
        end
      end
    end
    n_vec++;
    if (max_stall_hs < 1 || max_stall_hs > 2) begin
      n_err++;
      $display("FAIL bp_stall_beats: got %0d beats accepted during a stall expected 1..2", max_stall_hs);
    end
    n_vec++;
    if (unstable - u0 !== 0) begin
      n_err++;
      $display("FAIL bp_stable: got %0d changes while stalled expected 0", unstable - u0);
    end
    n_vec++;
    if (frame_len !== 16'd8 || n_done - d0 !== 1) begin
      n_err++;
      $display("FAIL bp_status: got len=%h done=%0d expected len=0008 done=1", frame_len, n_done - d0);
    end
  endtask

  task automatic test_timeout();
    int a0, e0, v0, k;
    cfg_arready_en = 1'b0; cfg_count = 16'd2; cfg_mode = 0;
    a0 = ar_log.size(); e0 = n_err_pulse; v0 = n_arvalid_cyc;
    start_frame();
    k = 0;
    while (n_err_pulse == e0 && k < 1200) begin
      step();
      k++;
    end
    for (int j = 0; j < 3; j++) step();
    n_vec++;
    if (n_err_pulse - e0 !== 1) begin
      n_err++;
      $display("FAIL timeout_err: got %0d pulses expected 1", n_err_pulse - e0);
    end
    n_vec++;
    if (n_arvalid_cyc - v0 !== 1024) begin
      n_err++;
      $display("FAIL timeout_cycles: got %0d arvalid cycles expected 1024", n_arvalid_cyc - v0);
    end
    n_vec++;
    if ({axi_arvalid, axi_rready} !== 2'b00 || ar_log.size() - a0 !== 0) begin
      n_err++;
      $display("FAIL timeout_idle: got ctl=%b requests=%0d expected ctl=00 requests=0",
               {axi_arvalid, axi_rready}, ar_log.size() - a0);
    end
    cfg_arready_en = 1'b1;
    step();
  endtask

  task automatic test_rlast_early();
    int o0, d0, e0;
    logic [32:0] exp_w;
    cfg_count = 16'd5; cfg_base = 32'hC000_0000; cfg_rlast_beat = 2; cfg_mode = 0;
    o0 = out_log.size(); d0 = n_done; e0 = n_err_pulse;
    start_frame();
    wait_words(o0 + 6, 100);
    n_vec++;
    if (out_log.size() - o0 !== 6) begin
      n_err++;
      $display("FAIL rlast_nwords: got %0d expected 6", out_log.size() - o0);
    end else begin
      for (int i = 0; i < 6; i++) begin
        exp_w = {(i == 5), 32'hC000_0000 + 32'(i)};
        n_vec++;
        if (out_log[o0+i] !== exp_w) begin
          n_err++;
          $display("FAIL rlast_word%0d: got %h expected %h", i, out_log[o0+i], exp_w);
        end
      end
    end
    n_vec++;
    if (n_err_pulse - e0 !== 1 || n_done - d0 !== 1 || frame_len !== 16'd6) begin
      n_err++;
      $display("FAIL rlast_status: got err=%0d done=%0d len=%h expected err=1 done=1 len=0006",
               n_err_pulse - e0, n_done - d0, frame_len);
    end
  endtask

  task automatic test_reset_mid_frame();
    int o0, d0, h0, k;
    cfg_count = 16'd5; cfg_base = 32'hD000_0000; cfg_rlast_beat = 5; cfg_mode = 2;
    o0 = out_log.size(); d0 = n_done; h0 = data_hs;
    start_frame();
    k = 0;
    while (data_hs - h0 < 2 && k < 50) begin
      step();
      k++;
    end
    n_vec++;
    if (data_hs - h0 !== 2 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_pre: got beats=%0d out_valid=%b expected beats=2 out_valid=1", data_hs - h0, out_valid);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({axi_arvalid, axi_rready, out_valid, out_last, frame_done, fetch_err} !== 6'b0 ||
        axi_araddr !== 32'd0 || out_data !== 32'd0 || frame_len !== 16'd0) begin
      n_err++;
      $display("FAIL midrst_async: got ctl=%b addr=%h data=%h len=%h expected all zero",
               {axi_arvalid, axi_rready, out_valid, out_last, frame_done, fetch_err},
               axi_araddr, out_data, frame_len);
    end
    for (int j = 0; j < 3; j++) step();
    rst = 1'b0;
    cfg_mode = 0;
    for (int j = 0; j < 10; j++) step();
    n_vec++;
    if (n_done - d0 !== 0 || out_log.size() - o0 !== 0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_after: got done=%0d words=%0d out_valid=%b expected 0 0 0",
               n_done - d0, out_log.size() - o0, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int a0, o0, d0, k;
    logic [32:0] exp_w;
    cfg_count = 16'd1; cfg_base = 32'hE000_0000; cfg_rlast_beat = 1; cfg_mode = 0;
    a0 = ar_log.size(); o0 = out_log.size(); d0 = n_done;
    rx_ready_int = 1'b1;
    k = 0;
    while (n_done - d0 < 2 && k < 100) begin
      step();
      k++;
    end
    rx_ready_int = 1'b0;
    for (int j = 0; j < 10; j++) step();
    n_vec++;
    if (ar_log.size() - a0 !== 4 || n_done - d0 !== 2) begin
      n_err++;
      $display("FAIL b2b_frames: got requests=%0d done=%0d expected requests=4 done=2",
               ar_log.size() - a0, n_done - d0);
    end
    n_vec++;
    if (out_log.size() - o0 !== 4) begin
      n_err++;
      $display("FAIL b2b_nwords: got %0d expected 4", out_log.size() - o0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp_w = {(i % 2 == 1), 32'hE000_0000 + 32'(i % 2)};
        n_vec++;
        if (out_log[o0+i] !== exp_w) begin
          n_err++;
          $display("FAIL b2b_word%0d: got %h expected %h", i, out_log[o0+i], exp_w);
        end
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    rx_ready_int   = 1'b0;
    cfg_count      = 16'd0;
    cfg_base       = 32'd0;
    cfg_rlast_beat = 0;
    cfg_arready_en = 1'b1;
    cfg_mode       = 0;
    test_reset();
    test_basic();
    test_invalid_count();
    test_backpressure();
    test_timeout();
    test_rlast_early();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
